// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment receive path: digit count and the
// active-high {g..a} hex glyphs produced by the display driver.
package ssd_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

endpackage

// File: rtl/seg_to_nibble.sv
// Inverse of the display driver's hex encoder: maps an active-high segment
// pattern back to its nibble; hit_out is low for any non-glyph pattern.
module seg_to_nibble
  import ssd_pkg::*;
(
  input  seg_t       seg_in,
  output logic [3:0] nib_out,
  output logic       hit_out
);

  always_comb begin
    nib_out = 4'h0;
    hit_out = 1'b1;
    case (seg_in)
      SEG_0:   nib_out = 4'h0;
      SEG_1:   nib_out = 4'h1;
      SEG_2:   nib_out = 4'h2;
      SEG_3:   nib_out = 4'h3;
      SEG_4:   nib_out = 4'h4;
      SEG_5:   nib_out = 4'h5;
      SEG_6:   nib_out = 4'h6;
      SEG_7:   nib_out = 4'h7;
      SEG_8:   nib_out = 4'h8;
      SEG_9:   nib_out = 4'h9;
      SEG_A:   nib_out = 4'hA;
      SEG_B:   nib_out = 4'hB;
      SEG_C:   nib_out = 4'hC;
      SEG_D:   nib_out = 4'hD;
      SEG_E:   nib_out = 4'hE;
      SEG_F:   nib_out = 4'hF;
      default: hit_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_decoder.sv
// Seven-segment bus monitor: synchronizes the scanned anode/cathode lines,
// samples each settled digit and reassembles the displayed 32-bit value.
module ssd_decoder
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT       = 1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [6:0]  cat_in,
  input  logic [7:0]  an_in,
  output logic [31:0] val_out,
  output logic        valid_out,
  output logic [7:0]  mask_out,
  output logic        err_out,
  output logic        stale_out
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0]  an_p0, an_p1;
  seg_t        cat_p0, cat_p1;
  logic [7:0]  an_s;
  seg_t        seg_s;
  logic [14:0] cur, prev;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] timer;
  logic [31:0] shadow, shadow_nx;
  logic [7:0]  mask_nx;
  logic [3:0]  nib;
  logic        hit;
  logic [2:0]  dig;
  logic        sample_evt, onehot, capture, err_evt, timeout_evt, frame_done;

  function automatic logic [SW-1:0] stab_inc(input logic [SW-1:0] c);
    return (c == SW'(SETTLE_CYCLES)) ? c : c + 1'b1;
  endfunction

  assign an_s  = ~an_p1;
  assign seg_s = ~cat_p1;
  assign cur   = {an_s, seg_s};

  seg_to_nibble u_dec (
    .seg_in  (seg_s),
    .nib_out (nib),
    .hit_out (hit)
  );

  always_comb begin
    dig = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_s[i]) dig = 3'(i);
  end

  // Fires exactly once per stable period, on the SETTLE-1 -> SETTLE step.
  assign sample_evt  = (cur == prev) && (stab_cnt == SW'(SETTLE_CYCLES - 1));
  assign onehot      = $onehot(an_s);
  assign capture     = sample_evt && onehot && hit;
  assign err_evt     = sample_evt && (an_s != 8'h00) && !(onehot && hit);
  assign timeout_evt = (timer == TW'(TIMEOUT - 1));

  // A capture coinciding with a timeout starts a fresh frame from this digit.
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[{dig, 2'b00} +: 4] = nib;
    mask_nx    = (timeout_evt ? 8'h00 : mask_out) | an_s;
    frame_done = (mask_nx == 8'hFF);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      an_p0     <= '0;
      an_p1     <= '0;
      cat_p0    <= '0;
      cat_p1    <= '0;
      prev      <= '0;
      stab_cnt  <= '0;
      timer     <= '0;
      shadow    <= '0;
      mask_out  <= '0;
      val_out   <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      stale_out <= 1'b0;
    end else begin
      an_p0  <= an_in;
      an_p1  <= an_p0;
      cat_p0 <= cat_in;
      cat_p1 <= cat_p0;
      prev   <= cur;
      stab_cnt <= (cur != prev) ? '0 : stab_inc(stab_cnt);
      valid_out <= 1'b0;
      err_out   <= err_evt;
      if (capture) begin
        timer     <= '0;
        stale_out <= 1'b0;
        shadow    <= shadow_nx;
        if (frame_done) begin
          val_out   <= shadow_nx;
          valid_out <= 1'b1;
          mask_out  <= 8'h00;
        end else begin
          mask_out  <= mask_nx;
        end
      end else begin
        if (timer != TW'(TIMEOUT)) timer <= timer + 1'b1;
        if (timeout_evt) begin
          mask_out  <= 8'h00;
          stale_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_decoder.sv
// Scoreboard bench for ssd_decoder: stimulus queues expected valid/err pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ssd_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 300;
  localparam int HOLD   = 10;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [6:0]  cat_in = 7'h7F;
  logic [7:0]  an_in  = 8'hFF;
  logic [31:0] val_out;
  logic        valid_out;
  logic [7:0]  mask_out;
  logic        err_out;
  logic        stale_out;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  ssd_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .cat_in    (cat_in),
    .an_in     (an_in),
    .val_out   (val_out),
    .valid_out (valid_out),
    .mask_out  (mask_out),
    .err_out   (err_out),
    .stale_out (stale_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic blank(input int n);
    an_in  = 8'hFF;
    cat_in = 7'h7F;
    tick(n);
  endtask

  task automatic show(input int k, input logic [6:0] seg);
    an_in  = ~(8'h01 << k);
    cat_in = ~seg;
    tick(HOLD);
    blank(2);
  endtask

  task automatic scan(input logic [31:0] v);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back('{1'b0, v});
      show(k, gly[v[4*k +: 4]]);
    end
  endtask

  // Anode leads cathode by 2 cycles, then a 1-cycle cathode glitch.
  task automatic scan_skew(input logic [31:0] v);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back('{1'b0, v});
      an_in = ~(8'h01 << k);
      tick(2);
      cat_in = ~7'h08;
      tick(1);
      cat_in = ~gly[v[4*k +: 4]];
      tick(HOLD);
    end
    blank(2);
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (valid_out || err_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, valid_out, err_out}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {31'd0, err_out}, {31'd0, e.is_err});
        if (!e.is_err) chk("frame_val", val_out, e.val);
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_val",   val_out, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_mask",  {24'd0, mask_out}, 32'd0);
    chk("rst_err",   {31'd0, err_out}, 32'd0);
    chk("rst_stale", {31'd0, stale_out}, 32'd0);
    rst_in = 1'b1;
    blank(8);

    scan(32'hDEADBEEF);
    scan(32'hDEADBEEF);
    chk("loop_val", val_out, 32'hDEADBEEF);

    show(0, gly[5]);
    scan_skew(32'h01234567);
    chk("skew_val", val_out, 32'h01234567);

    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        exp_q.push_back('{1'b1, 32'd0});
        show(k, 7'h00);
      end else begin
        show(k, gly[4'h8 + 4'(k)]);
      end
    end
    blank(3);
    chk("illegal_mask", {24'd0, mask_out}, 32'h0000_00F7);

    exp_q.push_back('{1'b1, 32'd0});
    an_in  = 8'b1111_1100;
    cat_in = ~gly[1];
    tick(HOLD);
    blank(3);
    chk("nonhot_mask", {24'd0, mask_out}, 32'h0000_00F7);

    blank(TMO + 20);
    chk("tmo1_mask",  {24'd0, mask_out}, 32'd0);
    chk("tmo1_stale", {31'd0, stale_out}, 32'd1);

    for (int k = 0; k < 5; k++) show(k, gly[k + 1]);
    chk("five_mask",  {24'd0, mask_out}, 32'h0000_001F);
    chk("five_stale", {31'd0, stale_out}, 32'd0);
    blank(TMO + 20);
    chk("tmo2_mask",  {24'd0, mask_out}, 32'd0);
    chk("tmo2_stale", {31'd0, stale_out}, 32'd1);
    chk("tmo2_val",   val_out, 32'h01234567);
    show(6, gly[4'hC]);
    chk("recap_mask",  {24'd0, mask_out}, 32'h0000_0040);
    chk("recap_stale", {31'd0, stale_out}, 32'd0);

    for (int k = 0; k < 6; k++) show(k, gly[4'hA]);
    chk("pre_rst_mask", {24'd0, mask_out}, 32'h0000_007F);
    an_in  = ~8'h40;
    cat_in = ~gly[2];
    tick(4);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_val",   val_out, 32'd0);
    chk("mid_rst_mask",  {24'd0, mask_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_err",   {31'd0, err_out}, 32'd0);
    chk("mid_rst_stale", {31'd0, stale_out}, 32'd0);
    blank(3);
    rst_in = 1'b1;
    blank(8);
    scan(32'h13579BDF);
    chk("post_rst_val", val_out, 32'h13579BDF);

    blank(20);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd_decoder.md
# ssd_decoder

Receive-side monitor for the multiplexed eight-digit seven-segment bus (active-low cathodes `{g,f,e,d,c,b,a}`, active-low one-hot anodes). It samples the scanned anode/cathode lines, decodes each stable digit back to a hex nibble, and reassembles the 32-bit value on display. It sits in loopback and self-check builds alongside the display driver, so the value being shown can be read back through the debug core.

## Interface
- `SETTLE_CYCLES`, default 16: consecutive cycles a synchronized pattern must be unchanged before it is sampled; legal range 1..65535.
- `TIMEOUT`, default 1_000_000: cycles without a successful capture before the partial frame is dropped.
- `clk_in`, in, 1: sole clock.
- `rst_in`, in, 1: reset; asynchronous assert, active-low.
- `cat_in`, in, 7: cathodes `{g,f,e,d,c,b,a}`, active-low; may be asynchronous to `clk_in`.
- `an_in`, in, 8: anodes, active-low; bit k selects digit k; may be asynchronous.
- `val_out`, out, 32: last completed frame; nibble k is `val_out[4k+3:4k]`.
- `valid_out`, out, 1: one-cycle pulse when `val_out` is updated.
- `mask_out`, out, 8: digits captured in the current, not yet completed frame.
- `err_out`, out, 1: one-cycle pulse on a sample whose anode is not one-hot, or whose segment pattern is not a hex glyph.
- `stale_out`, out, 1: high from a timeout until the next successful capture.

## Operation
- **Input sync.** `an_in` and `cat_in` each pass through two flops, then are inverted to active-high `an_s` and `seg_s`.
- **Stability tracking.** `prev` holds the previous `{an_s, seg_s}`.
  - If the current value differs from `prev`, `stab_cnt` is set to 0.
  - Otherwise `stab_cnt` increments and saturates at `SETTLE_CYCLES`.
  - A sample event fires on the cycle `stab_cnt` goes from `SETTLE_CYCLES-1` to `SETTLE_CYCLES`, i.e. exactly once per stable period.
- **Sample event handling.**
  - `an_s == 0` (blanked): ignored; no error, no timer reset.
  - `an_s` not one-hot: `err_out` pulse, nothing captured.
  - One-hot `an_s` with bit k set: `seg_s` is looked up against the glyphs 0..F.
    - Glyph values: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
    - No match: `err_out` pulse, nothing captured.
    - Match: `shadow[k]` takes the nibble, `mask[k]` is set, and the stale timer is cleared.
  - Recapturing a digit already in `mask` overwrites `shadow[k]`; this is not an error.
- **Frame completion.** When a capture makes `mask == 8'hFF`:
  - `val_out` takes `shadow` including the new nibble.
  - `valid_out` pulses.
  - `mask` clears to 0 in the same update.
- **Stale timer.** Counts cycles since the last successful capture.
  - On reaching `TIMEOUT`: `mask` clears, `stale_out` goes high, and the counter holds.
  - `val_out` is retained.
  - `stale_out` drops on the next successful capture.
- **Simultaneous events.** A timeout and a capture in the same cycle: the capture wins. `mask` becomes only the new bit and `stale_out` stays low.
- **Reset.** Asynchronous. All outputs 0: `val_out=0`, `valid_out=0`, `mask_out=0`, `err_out=0`, `stale_out=0`. Sync flops, `prev`, `stab_cnt`, the timer and `shadow` are also 0. Reset mid-frame discards the partial frame.

## Timing
- An input change at edge N becomes visible in `an_s`/`seg_s` at N+2.
- With the input held, the sample event occurs at N+2+`SETTLE_CYCLES`.
- `shadow`, `mask_out`, `val_out`, `valid_out` and `err_out` are registered and update at N+3+`SETTLE_CYCLES`.
- Anode and cathode edges that are skewed by less than `SETTLE_CYCLES` cycles produce a single sample of the final pattern.
- Ghost glyphs during the scan transition are filtered by the settle window and never reach the decode.
- Minimum frame time is 8 × (`SETTLE_CYCLES`+1) cycles.
- `valid_out` and `err_out` are never high for more than one consecutive cycle per event.

## Structure
- **`ssd_pkg`:**
  - `NUM_DIGITS = 8`.
  - The 16 glyph constants `SEG_0`..`SEG_F`, 7-bit, active-high `{g..a}`.
  - A typedef for the 7-bit segment vector.
- **`seg_to_nibble`** (combinational): 7-bit pattern in, 4-bit nibble plus `hit` out. It is the inverse of the display driver's hex encoder.
- Everything else lives in `ssd_decoder`: sync, stability counter, capture and frame logic, stale timer.

## Test plan
- **Loopback.** Display driver with a short scan period drives `0xDEADBEEF`, with `SETTLE_CYCLES=4` → `valid_out` pulses once per scan, `val_out=0xDEADBEEF`, `err_out` never high.
- **Skew and glitches.** Anode changes 2 cycles before the cathode, with 1-cycle glitches on the cathode → no `err_out`, and the decoded value is still correct.
- **Illegal glyph.** Digit 3 is shown as `seg=0x00` → `err_out` pulses; `mask_out` holds `0xF7` after the other 7 digits; no `valid_out`.
- **Non-one-hot anode.** `an_in=8'b1111_1100` held stable → one `err_out` pulse, and `mask_out` is unchanged.
- **Timeout.** 5 digits are captured, then inputs freeze blank for `TIMEOUT` cycles → `mask_out=0`, `stale_out=1`, `val_out` is retained. The next capture drops `stale_out`, and `mask_out` shows a single bit.
- **Reset mid-frame.** Assert `rst_in` low after 6 digits → all outputs read 0 immediately. After release, a full new frame gives `val_out` equal to the new value only.
